sdg_sched: RTL and testbench

SDG_SCHED -- requirements
Module: sdg_sched

---
 rtl/sdg_sched.sv | 123 ++++++++++++
 tb/tb_sdg_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sdg_sched.sv
// Self-decimating LFSR keystream scheduler: a 32-bit Fibonacci LFSR whose step period
// depends on state parity, with a valid/ready output. Optional step counter: SDG_STEPCNT_EN.
module sdg_sched #(
  parameter logic [3:0] D0 = 4'd2,
  parameter logic [3:0] D1 = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  output logic        seed_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bit,
  output logic [31:0] lfsr_o,
  output logic        busy,
  output logic [15:0] step_cnt
);

  localparam int unsigned LW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] P0 = (D0 == 4'd0) ? 4'd1 : D0;
  localparam logic [CW-1:0] P1 = (D1 == 4'd0) ? 4'd1 : D1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] seed_load;
  logic [LW-1:0] s_seeded;
  logic [LW-1:0] s_next;

  function automatic logic [CW-1:0] period(input logic [LW-1:0] v);
    return (^v) ? P1 : P0;
  endfunction

  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_load = (seed == 32'h0) ? 32'h0000_0001 : seed;
  assign s_seeded  = seed_valid ? seed_load : lfsr_o;
  assign s_next    = lfsr_step(lfsr_o);
  assign out_bit   = lfsr_o[31];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr_o     <= 32'h0000_0001;
      cnt        <= '0;
      out_valid  <= 1'b0;
      seed_ready <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_valid) lfsr_o <= seed_load;
          if (start && !stop) begin
            state      <= RUN;
            cnt        <= period(s_seeded);
            busy       <= 1'b1;
            seed_ready <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            seed_ready <= 1'b1;
          end else if (out_valid && !out_ready) begin
            state <= HOLD;
          end else if (cnt == 4'd1) begin
            lfsr_o    <= s_next;
            cnt       <= period(s_next);
            out_valid <= 1'b1;
          end else begin
            cnt       <= cnt - 4'd1;
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (stop) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            seed_ready <= 1'b1;
          end else if (out_ready) begin
            state     <= RUN;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          seed_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SDG_STEPCNT_EN
  logic step_c;

  // Mirrors the RUN step condition above; wraps naturally at 16 bits.
  assign step_c = (state == RUN) && !stop && !(out_valid && !out_ready) && (cnt == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) step_cnt <= 16'h0000;
    else if (step_c) step_cnt <= step_cnt + 16'd1;
  end
`else
  assign step_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sdg_sched.sv
// Directed bench for sdg_sched: reset, seeding, step timing, backpressure, stop and step counting.
module tb_sdg_sched;

  logic        clk = 1'b0;
  logic        rst, start, stop, seed_valid, out_ready;
  logic [31:0] seed;
  logic        seed_ready, out_valid, out_bit, busy;
  logic [31:0] lfsr_o;
  logic [15:0] step_cnt;

  logic        start1, stop1;
  logic        seed_ready1, out_valid1, out_bit1, busy1;
  logic [31:0] lfsr_o1;
  logic [15:0] step_cnt1;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  sdg_sched #(.D0(4'd2), .D1(4'd1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed_valid(seed_valid), .seed(seed), .seed_ready(seed_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .lfsr_o(lfsr_o), .busy(busy), .step_cnt(step_cnt)
  );

  sdg_sched #(.D0(4'd1), .D1(4'd1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1),
    .seed_valid(1'b0), .seed(32'h0), .seed_ready(seed_ready1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_bit(out_bit1),
    .lfsr_o(lfsr_o1), .busy(busy1), .step_cnt(step_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int unsigned n);
`ifdef SDG_STEPCNT_EN
    return 16'(n % 65536);
`else
    return 16'(n & 0);
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_lfsr"}, lfsr_o, 32'h0000_0001);
    check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sready"}, 32'(seed_ready), 32'd1);
    check({tag, "_obit"}, 32'(out_bit), 32'd0);
    check({tag, "_stepcnt"}, 32'(step_cnt), 32'(exp_cnt(0)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; seed_valid = 1'b0; seed = 32'h0; out_ready = 1'b1;
    start1 = 1'b0; stop1 = 1'b0;
    tick(); tick();
    check_reset_vals("reset");
    rst = 1'b0;

    // Seeding in IDLE, including the zero-seed substitution
    seed_valid = 1'b1; seed = 32'h1234_5678;
    tick();
    check("seed_load", lfsr_o, 32'h1234_5678);
    seed = 32'h0;
    tick();
    check("zero_seed", lfsr_o, 32'h0000_0001);
    seed_valid = 1'b0;

    // start together with stop keeps IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    check("start_stop_busy", 32'(busy), 32'd0);
    check("start_stop_sready", 32'(seed_ready), 32'd1);

    // Start: parity(1)=1 -> period 1, first step on first RUN edge
    stop = 1'b0;
    tick();
    start = 1'b0;
    check("run_busy", 32'(busy), 32'd1);
    check("run_sready", 32'(seed_ready), 32'd0);
    check("run_lfsr0", lfsr_o, 32'h0000_0001);
    seed_valid = 1'b1; seed = 32'hFFFF_FFFF;
    tick();
    check("step1_lfsr", lfsr_o, 32'h0000_0003);
    check("step1_valid", 32'(out_valid), 32'd1);
    check("step1_bit", 32'(out_bit), 32'd0);
    tick();
    check("gap_lfsr", lfsr_o, 32'h0000_0003);
    check("gap_valid", 32'(out_valid), 32'd0);
    tick();
    seed_valid = 1'b0;
    check("step2_lfsr", lfsr_o, 32'h0000_0006);
    check("step2_valid", 32'(out_valid), 32'd1);

    // Backpressure: HOLD freezes everything for 5 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_lfsr", lfsr_o, 32'h0000_0006);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_bit", 32'(out_bit), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_lfsr", lfsr_o, 32'h0000_0006);
    tick();
    check("resume_lfsr", lfsr_o, 32'h0000_0006);
    check("resume_valid", 32'(out_valid), 32'd0);
    tick();
    check("step3_lfsr", lfsr_o, 32'h0000_000D);
    check("step3_valid", 32'(out_valid), 32'd1);
    check("step3_cnt", 32'(step_cnt), 32'(exp_cnt(3)));

    // Stop in RUN discards pending bit, keeps state
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_valid", 32'(out_valid), 32'd0);
    check("stop_lfsr", lfsr_o, 32'h0000_000D);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_sready", 32'(seed_ready), 32'd1);
    tick();
    check("stop_hold_lfsr", lfsr_o, 32'h0000_000D);
    check("stop_hold_cnt", 32'(step_cnt), 32'(exp_cnt(3)));

    // Seed with bit30 set to produce out_bit=1, then stall and reset mid-HOLD
    seed_valid = 1'b1; seed = 32'h4000_0000; start = 1'b1; out_ready = 1'b0;
    tick();
    seed_valid = 1'b0; start = 1'b0;
    check("seed2_lfsr", lfsr_o, 32'h4000_0000);
    check("seed2_busy", 32'(busy), 32'd1);
    tick();
    check("msb_lfsr", lfsr_o, 32'h8000_0000);
    check("msb_bit", 32'(out_bit), 32'd1);
    check("msb_valid", 32'(out_valid), 32'd1);
    tick(); tick();
    check("hold2_lfsr", lfsr_o, 32'h8000_0000);
    check("hold2_cnt", 32'(step_cnt), 32'(exp_cnt(4)));
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; out_ready = 1'b1;
    check_reset_vals("midhold_reset");

    // 70000 steps at period 1 on the second instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("long_busy", 32'(busy1), 32'd1);
    repeat (70000) tick();
    stop1 = 1'b1;
    tick();
    stop1 = 1'b0;
    check("long_stepcnt", 32'(step_cnt1), 32'(exp_cnt(70000)));
    check("long_idle", 32'(busy1), 32'd0);
    check("long_valid", 32'(out_valid1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
